// File: rtl/pixel_stream_ctrl.sv
// Frame sequencer: paces per-pixel requests to the sensor producer, absorbs the
// one-cycle request-to-data latency in a 4-entry skid FIFO and re-emits frame-marked pixels.
module pixel_stream_ctrl #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int GAP_CYCLES = 4
) (
  input  logic        sensor_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  frames_req,
  output logic        prod_ready,
  input  logic [7:0]  prod_pixel,
  input  logic        prod_valid,
  output logic [7:0]  out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frames_done,
  output logic        ovf_err
);
  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int REQ_W = $clog2(FRAME_PIXELS + 1);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0]       mem_q [4];
  logic [7:0]       mem_d [4];
  logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [REQ_W-1:0] req_cnt_q, req_cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic [7:0]       frames_req_q, frames_req_d;
  logic [15:0]      frames_done_q, frames_done_d;
  logic             ovf_q, ovf_d;

  logic pop, push, abort_act, head_last_col, head_eof, more_frames;

  always_comb begin
    out_valid     = (count_q != 3'd0);
    pop           = out_valid & out_ready;
    abort_act     = abort & (state_q != S_IDLE);
    head_last_col = (col_q == COL_W'(IMG_WIDTH - 1));
    head_eof      = head_last_col & (row_q == ROW_W'(IMG_HEIGHT - 1));
    out_pixel     = out_valid ? mem_q[rd_ptr_q] : 8'd0;
    out_sof       = out_valid & (col_q == '0) & (row_q == '0);
    out_eol       = out_valid & head_last_col;
    out_eof       = out_valid & head_eof;
    // Counting the in-flight pixel makes the FIFO unable to overflow.
    prod_ready    = (state_q == S_STREAM) & (req_cnt_q < REQ_W'(FRAME_PIXELS)) &
                    (({1'b0, count_q} + {3'b000, prod_valid}) < 4'd4) & !abort_act;
    push          = prod_valid & (state_q != S_FLUSH) & ((count_q != 3'd4) | pop);
    frame_done    = pop & head_eof & (state_q == S_DRAIN) & !abort_act;
    more_frames   = (frames_req_q == 8'd0) |
                    (({1'b0, frame_cnt_q} + 9'd1) < {1'b0, frames_req_q});
    busy          = (state_q != S_IDLE);
    frames_done   = frames_done_q;
    ovf_err       = ovf_q;
  end

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + 3'(push) - 3'(pop);
    req_cnt_d     = req_cnt_q;
    col_d         = col_q;
    row_d         = row_q;
    gap_cnt_d     = gap_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    frames_req_d  = frames_req_q;
    frames_done_d = frames_done_q;
    ovf_d         = ovf_q | (prod_valid & (count_q == 3'd4));

    if (push) begin
      mem_d[wr_ptr_q] = prod_pixel;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      if (head_last_col) begin
        col_d = '0;
        row_d = head_eof ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
    if (prod_ready) req_cnt_d = req_cnt_q + REQ_W'(1);

    case (state_q)
      S_IDLE: if (start && !abort) begin
        state_d      = S_STREAM;
        frames_req_d = frames_req;
        req_cnt_d    = '0;
        col_d        = '0;
        row_d        = '0;
        frame_cnt_d  = '0;
      end
      S_STREAM: if (req_cnt_q == REQ_W'(FRAME_PIXELS)) state_d = S_DRAIN;
      S_DRAIN: if (frame_done) begin
        frame_cnt_d   = frame_cnt_q + 8'd1;
        frames_done_d = frames_done_q + 16'd1;
        if (more_frames) begin
          req_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? S_STREAM : S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (32'(gap_cnt_q) + 32'd1 >= 32'(GAP_CYCLES)) state_d = S_STREAM;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort beats any frame transition and drops whatever is buffered or in flight.
    if (abort_act) begin
      state_d  = S_FLUSH;
      count_d  = 3'd0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
    end
  end

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mem_q         <= '{default: 8'd0};
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      req_cnt_q     <= '0;
      col_q         <= '0;
      row_q         <= '0;
      gap_cnt_q     <= '0;
      frame_cnt_q   <= 8'd0;
      frames_req_q  <= 8'd0;
      frames_done_q <= 16'd0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      req_cnt_q     <= req_cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      frames_req_q  <= frames_req_d;
      frames_done_q <= frames_done_d;
      ovf_q         <= ovf_d;
    end
  end
endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// Bench for pixel_stream_ctrl: a producer model honours the 1-cycle latency contract and a
// scoreboard queue holds the expected pixel/marker stream that the output monitor pops against.
module tb_pixel_stream_ctrl;
  localparam int W   = 32;
  localparam int H   = 32;
  localparam int F   = W * H;
  localparam int GAP = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0]  frames_req = 8'd0, prod_pixel = 8'd0;
  logic        prod_valid = 1'b0, out_ready = 1'b0;
  logic        prod_ready, out_valid, out_sof, out_eol, out_eof, busy, frame_done, ovf_err;
  logic [7:0]  out_pixel;
  logic [15:0] frames_done;

  always #5 clk = ~clk;

  pixel_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .GAP_CYCLES(GAP)) dut (
    .sensor_clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frames_req(frames_req),
    .prod_ready(prod_ready), .prod_pixel(prod_pixel), .prod_valid(prod_valid),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy),
    .frame_done(frame_done), .frames_done(frames_done), .ovf_err(ovf_err)
  );

  typedef struct packed { logic [7:0] pix; logic sof; logic eol; logic eof; } exp_t;
  exp_t sb_q[$];
  int   n_checks = 0, n_pass = 0;
  bit   sb_en = 1'b0;
  int   exp_idx = 0, occ = 0, pcnt = 0, or_mode = 0;
  int   fd_cnt = 0, pop_cnt = 0, sof_cnt = 0, eol_cnt = 0, eof_cnt = 0;
  logic rdy_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Producer: answers each prod_ready cycle with a pixel exactly one cycle later.
  always @(negedge clk) rdy_s = prod_ready;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prod_valid = 1'b0;
      pcnt = 0;
    end else begin
      prod_valid = rdy_s;
      if (rdy_s) begin
        prod_pixel = 8'(pcnt);
        pcnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 3);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compares the presented head against the scoreboard every valid cycle.
  always @(negedge clk) begin
    if (!rst_n || !sb_en) begin
      sb_q.delete();
      occ = 0;
    end else begin
      occ = sb_q.size();
      if (prod_ready) check("ready_rule", 32'(occ + int'(prod_valid) < 4), 32'd1);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("out_valid_without_pixel", 32'(out_valid), 32'd0);
        end else begin
          check("head_pixel_markers", 32'({out_pixel, out_sof, out_eol, out_eof}), 32'(sb_q[0]));
          if (out_ready) begin
            check("frame_done_at_pop", 32'(frame_done), 32'(sb_q[0].eof));
            void'(sb_q.pop_front());
            pop_cnt++;
            sof_cnt += int'(out_sof);
            eol_cnt += int'(out_eol);
            eof_cnt += int'(out_eof);
          end
        end
      end
      if (frame_done && !(out_valid && out_ready)) check("frame_done_stray", 32'(frame_done), 32'd0);
      if (prod_valid) begin
        sb_q.push_back('{pix: prod_pixel, sof: (exp_idx % F) == 0,
                         eol: (exp_idx % W) == W - 1, eof: (exp_idx % F) == F - 1});
        exp_idx++;
      end
    end
    if (rst_n && frame_done) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    frames_req = n;
    start = 1'b1;
    sb_en = 1'b1;
    exp_idx = 0;
    fd_cnt = 0; pop_cnt = 0; sof_cnt = 0; eol_cnt = 0; eof_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fd(input string name, input int target, input int budget);
    int k = 0;
    while (fd_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(fd_cnt), 32'(target));
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    sb_en = 1'b0;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g, first_r, first_v;
    logic [15:0] fd_before;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({prod_ready, out_valid, out_sof, out_eol, out_eof, busy,
                                frame_done, ovf_err, out_pixel, frames_done}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Single frame at full rate, with first-pixel latency.
    or_mode = 0;
    do_start(8'd1);
    first_r = -1; first_v = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prod_ready && first_r < 0) first_r = i;
      if (out_valid && first_v < 0) first_v = i;
    end
    check("first_pixel_latency", 32'(first_v - first_r), 32'd2);
    tick();
    wait_fd("single_frame_done", 1, 3000);
    check("single_busy_idle", 32'(busy), 32'd0);
    check("single_frames_done", 32'(frames_done), 32'd1);
    check("single_pop_count", 32'(pop_cnt), 32'(F));
    check("single_sof_count", 32'(sof_cnt), 32'd1);
    check("single_eol_count", 32'(eol_cnt), 32'(H));
    check("single_eof_count", 32'(eof_cnt), 32'd1);
    tick();
    check("single_no_extra_frame_done", 32'(fd_cnt), 32'd1);

    // Backpressure at ~30% out_ready duty.
    or_mode = 1;
    do_start(8'd1);
    wait_fd("bp_frame_done", 1, 10000);
    check("bp_pop_count", 32'(pop_cnt), 32'(F));
    check("bp_ovf_err", 32'(ovf_err), 32'd0);
    check("bp_frames_done", 32'(frames_done), 32'd2);
    or_mode = 0;
    tick();

    // Three frames separated by the inter-frame gap.
    do_start(8'd3);
    for (int f = 1; f <= 2; f++) begin
      wait_fd("multi_frame_done", f, 3000);
      check("multi_busy_between", 32'(busy), 32'd1);
      g = 0;
      while (1) begin
        @(negedge clk);
        if (prod_ready || g >= 20) break;
        g++;
      end
      check("multi_gap_cycles", 32'(g), 32'(GAP));
      tick();
    end
    wait_fd("multi_frame_done", 3, 3000);
    check("multi_busy_after_last", 32'(busy), 32'd0);
    check("multi_frames_done", 32'(frames_done), 32'd5);
    check("multi_pop_count", 32'(pop_cnt), 32'(3 * F));

    // Asynchronous reset mid-stream with three pixels buffered.
    or_mode = 2;
    do_start(8'd1);
    for (int i = 0; i < 20 && occ != 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("reset_setup_fifo3", 32'(occ), 32'd3);
    rst_n = 1'b0;
    sb_en = 1'b0;
    #1;
    check("reset_mid_out_valid", 32'(out_valid), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
    check("reset_mid_frames_done", 32'(frames_done), 32'd0);
    check("reset_mid_all_outputs", 32'({prod_ready, out_sof, out_eol, out_eof, frame_done,
                                        ovf_err, out_pixel}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    or_mode = 0;
    tick();

    // Abort around pixel 500 with data buffered and in flight.
    do_start(8'd1);
    for (int i = 0; i < 2000 && pop_cnt < 500; i++) tick();
    fd_before = frames_done;
    abort = 1'b1;
    sb_en = 1'b0;
    @(negedge clk);
    check("abort_prod_ready_low", 32'(prod_ready), 32'd0);
    check("abort_fifo_nonempty", 32'(out_valid), 32'd1);
    check("abort_pixel_in_flight", 32'(prod_valid), 32'd1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_frames_done_kept", 32'(frames_done), 32'(fd_before));
    tick();
    do_start(8'd1);
    check("restart_after_abort", 32'(busy), 32'd1);
    wait_fd("restart_frame_done", 1, 3000);
    check("restart_frames_done", 32'(frames_done), 32'd1);

    // start together with abort while idle is ignored.
    frames_req = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);

    // A second start during STREAM must not relatch frames_req.
    do_start(8'd1);
    repeat (100) tick();
    frames_req = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_fd("stream_start_frame_done", 1, 3000);
    check("stream_start_ignored", 32'(busy), 32'd0);
    check("stream_start_frames_done", 32'(frames_done), 32'd2);

    // Continuous mode runs until aborted.
    do_start(8'd0);
    wait_fd("continuous_frames", 2, 5000);
    check("continuous_still_busy", 32'(busy), 32'd1);
    repeat (50) tick();
    pulse_abort();
    tick();
    check("continuous_abort_idle", 32'(busy), 32'd0);
    check("continuous_frames_done", 32'(frames_done), 32'd4);

    // frames_done wraps from 0xFFFF to 0.
    force dut.frames_done_q = 16'hFFFF;
    #1;
    release dut.frames_done_q;
    #1;
    check("wrap_preset", 32'(frames_done), 32'h0000_FFFF);
    do_start(8'd1);
    wait_fd("wrap_frame_done", 1, 3000);
    check("wrap_frames_done", 32'(frames_done), 32'd0);
    check("final_ovf_err", 32'(ovf_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
